// File: rtl/mem_sweep_pkg.sv
// Shared types, mode encodings and the signature step function for the memory sweep controller.
package mem_sweep_pkg;

    typedef enum logic [2:0] {StIdle, StFill, StRead, StDrain, StDone} state_e;

    localparam logic MODE_SIGN        = 1'b0;
    localparam logic MODE_FILL_VERIFY = 1'b1;

    localparam int unsigned SigMaxW = 64;

    // Rotate-left-by-one then XOR, confined to the low w bits (w <= SigMaxW).
    function automatic logic [SigMaxW-1:0] sig_step(input logic [SigMaxW-1:0] sig,
                                                    input logic [SigMaxW-1:0] data,
                                                    input int unsigned w);
        logic [SigMaxW-1:0] mask;
        mask = (w >= SigMaxW) ? '1 : ((SigMaxW'(1) << w) - SigMaxW'(1));
        return (((sig << 1) | (sig >> (w - 1))) ^ data) & mask;
    endfunction

endpackage

// File: rtl/mem_sweep_sig.sv
// Rotate-XOR signature accumulator with synchronous clear and enable.
module mem_sweep_sig
    import mem_sweep_pkg::*;
#(
    parameter int unsigned SIG_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic [SIG_W-1:0] data_i,
    output logic [SIG_W-1:0] sig_o
);

    logic [SIG_W-1:0] sig_q, sig_d;

    always_comb begin
        sig_d = sig_q;
        if (clr_i) begin
            sig_d = '0;
        end else if (en_i) begin
            sig_d = SIG_W'(sig_step(SigMaxW'(sig_q), SigMaxW'(data_i), SIG_W));
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sig_q <= '0;
        end else begin
            sig_q <= sig_d;
        end
    end

    assign sig_o = sig_q;

endmodule

// File: rtl/mem_sweep_ctrl.sv
// Sweep controller for a write-every-cycle, read-first memory: fill/verify or
// non-destructive signature read-back over an address range.
module mem_sweep_ctrl
    import mem_sweep_pkg::*;
#(
    parameter int unsigned WID_MEM   = 4,
    parameter int unsigned DEPTH_MEM = 4096,
    parameter int unsigned PARK_ADDR = DEPTH_MEM - 1,
    parameter int unsigned SIG_W     = 32
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               start_i,
    input  logic               mode_i,
    input  logic [31:0]        base_i,
    input  logic [31:0]        len_i,
    input  logic [WID_MEM-1:0] seed_i,
    input  logic [WID_MEM-1:0] mem_dout_i,
    output logic [31:0]        raddr_o,
    output logic [31:0]        waddr_o,
    output logic [WID_MEM-1:0] din_o,
    output logic               busy_o,
    output logic               done_o,
    output logic               cfg_err_o,
    output logic [31:0]        err_count_o,
    output logic [SIG_W-1:0]   signature_o
);

    localparam logic [31:0] Park = 32'(PARK_ADDR);

    function automatic logic [WID_MEM-1:0] pat(input logic [31:0] a, input logic [WID_MEM-1:0] s);
        return a[WID_MEM-1:0] ^ s;
    endfunction

    state_e             state_q;
    logic               mode_q;
    logic [31:0]        base_q, len_q, k_q;
    logic [WID_MEM-1:0] seed_q;
    logic [31:0]        raddr_q, waddr_q, err_count_q;
    logic [WID_MEM-1:0] din_q;
    logic               wb_q, busy_q, done_q, cfg_err_q;

    logic [32:0] range_end;
    logic        range_bad, accept;

    assign range_end = {1'b0, base_i} + {1'b0, len_i};
    assign range_bad = range_end > 33'(DEPTH_MEM);
    assign accept    = (state_q == StIdle) && start_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            mode_q      <= MODE_SIGN;
            base_q      <= '0;
            len_q       <= '0;
            k_q         <= '0;
            seed_q      <= '0;
            raddr_q     <= Park;
            waddr_q     <= Park;
            din_q       <= '0;
            wb_q        <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            cfg_err_q   <= 1'b0;
            err_count_q <= '0;
        end else begin
            done_q <= 1'b0;
            // wb_q marks a cycle whose mem_dout is the word at waddr_q.
            if (wb_q && mode_q == MODE_FILL_VERIFY && mem_dout_i != pat(waddr_q, seed_q)
                && err_count_q != '1) begin
                err_count_q <= err_count_q + 32'd1;
            end
            unique case (state_q)
                StIdle: begin
                    raddr_q <= Park;
                    waddr_q <= Park;
                    din_q   <= '0;
                    wb_q    <= 1'b0;
                    if (start_i) begin
                        mode_q      <= mode_i;
                        base_q      <= base_i;
                        len_q       <= len_i;
                        seed_q      <= seed_i;
                        k_q         <= '0;
                        err_count_q <= '0;
                        cfg_err_q   <= 1'b0;
                        if (range_bad) begin
                            cfg_err_q <= 1'b1;
                            done_q    <= 1'b1;
                            state_q   <= StDone;
                        end else if (len_i == 32'd0) begin
                            done_q  <= 1'b1;
                            state_q <= StDone;
                        end else if (mode_i == MODE_FILL_VERIFY) begin
                            busy_q  <= 1'b1;
                            waddr_q <= base_i;
                            din_q   <= pat(base_i, seed_i);
                            state_q <= StFill;
                        end else begin
                            busy_q  <= 1'b1;
                            raddr_q <= base_i;
                            state_q <= StRead;
                        end
                    end
                end
                StFill: begin
                    if (k_q == len_q - 32'd1) begin
                        k_q     <= '0;
                        raddr_q <= base_q;
                        waddr_q <= Park;
                        din_q   <= '0;
                        state_q <= StRead;
                    end else begin
                        k_q     <= k_q + 32'd1;
                        waddr_q <= base_q + k_q + 32'd1;
                        din_q   <= pat(base_q + k_q + 32'd1, seed_q);
                    end
                end
                StRead: begin
                    wb_q    <= 1'b1;
                    waddr_q <= base_q + k_q;
                    din_q   <= '0;
                    if (k_q == len_q - 32'd1) begin
                        raddr_q <= Park;
                        state_q <= StDrain;
                    end else begin
                        k_q     <= k_q + 32'd1;
                        raddr_q <= base_q + k_q + 32'd1;
                    end
                end
                StDrain: begin
                    raddr_q <= Park;
                    waddr_q <= Park;
                    din_q   <= '0;
                    wb_q    <= 1'b0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    state_q <= StDone;
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    mem_sweep_sig #(
        .SIG_W(SIG_W)
    ) u_sig (
        .clk_i (clk_i),
        .rst_ni(rst_ni),
        .clr_i (accept),
        .en_i  (wb_q),
        .data_i(SIG_W'(mem_dout_i)),
        .sig_o (signature_o)
    );

    // Write-back data must be the word arriving this cycle, so it bypasses din_q.
    assign din_o       = wb_q ? mem_dout_i : din_q;
    assign raddr_o     = raddr_q;
    assign waddr_o     = waddr_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign cfg_err_o   = cfg_err_q;
    assign err_count_o = err_count_q;

endmodule

// File: tb/tb_mem_sweep_ctrl.sv
// Scoreboard bench for mem_sweep_ctrl paired with a read-first, 1-cycle memory model.
module tb_mem_sweep_ctrl;

    localparam logic [31:0] PARK = 32'd4095;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        mode = 1'b0;
    logic [31:0] base = '0, len = '0;
    logic [3:0]  seed = '0;
    logic [3:0]  mem_dout;
    logic [31:0] raddr, waddr, err_count, signature;
    logic [3:0]  din;
    logic        busy, done, cfg_err;

    int cyc = 0;
    int n_checks = 0;
    int n_fail = 0;

    typedef struct {
        int          cyc;
        logic        cfg;
        logic [31:0] err;
        logic [31:0] sig;
    } exp_t;
    exp_t exp_q[$];
    exp_t mon_e;

    // Memory model
    logic [3:0]  ram [4096];
    logic [3:0]  mem_q;
    logic [31:0] last_raddr;
    logic        pre_we = 1'b0, flip_en = 1'b0;
    logic [11:0] pre_addr = '0;
    logic [3:0]  pre_data = '0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        mem_q <= ram[raddr[11:0]];
        last_raddr <= raddr;
        ram[waddr[11:0]] <= din;
        if (pre_we) ram[pre_addr] <= pre_data;
    end
    assign mem_dout = mem_q ^ ((flip_en && last_raddr == 32'd5) ? 4'h1 : 4'h0);

    always #5 clk = ~clk;

    mem_sweep_ctrl u_dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .start_i    (start),
        .mode_i     (mode),
        .base_i     (base),
        .len_i      (len),
        .seed_i     (seed),
        .mem_dout_i (mem_dout),
        .raddr_o    (raddr),
        .waddr_o    (waddr),
        .din_o      (din),
        .busy_o     (busy),
        .done_o     (done),
        .cfg_err_o  (cfg_err),
        .err_count_o(err_count),
        .signature_o(signature)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] sig_ref(input logic [31:0] s, input logic [3:0] d);
        return {s[30:0], s[31]} ^ {28'd0, d};
    endfunction

    // Monitor: every done pulse is matched against the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check("done_cycle", 32'(cyc), 32'(mon_e.cyc));
                check("done_busy", {31'd0, busy}, 32'd0);
                check("cfg_err", {31'd0, cfg_err}, {31'd0, mon_e.cfg});
                check("err_count", err_count, mon_e.err);
                check("signature", signature, mon_e.sig);
            end
        end
    end

    task automatic preload(input logic [11:0] a, input logic [3:0] d);
        @(negedge clk);
        pre_we = 1'b1; pre_addr = a; pre_data = d;
        @(posedge clk);
        #1 pre_we = 1'b0;
    endtask

    task automatic run_start(input logic m, input logic [31:0] b, input logic [31:0] l,
                             input logic [3:0] s, input int lat, input logic cfg,
                             input logic [31:0] err, input logic [31:0] sig);
        exp_t e;
        @(negedge clk);
        start = 1'b1; mode = m; base = b; len = l; seed = s;
        e.cyc = cyc + lat; e.cfg = cfg; e.err = err; e.sig = sig;
        exp_q.push_back(e);
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        for (int i = 0; i < budget && exp_q.size() != 0; i++) @(negedge clk);
        if (exp_q.size() != 0) begin
            check("done_timeout", 32'(exp_q.size()), 32'd0);
            exp_q.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        logic [31:0] es;
        logic [3:0]  d;

        repeat (3) @(negedge clk);
        check("rst_raddr", raddr, PARK);
        check("rst_waddr", waddr, PARK);
        check("rst_din", {28'd0, din}, 32'd0);
        check("rst_flags", {29'd0, busy, done, cfg_err}, 32'd0);
        check("rst_err", err_count, 32'd0);
        check("rst_sig", signature, 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i <= 20; i++) preload(12'(i), 4'h7);

        // FILL_VERIFY base 0 len 16 seed A
        es = '0;
        for (int k = 0; k < 16; k++) es = sig_ref(es, 4'(k) ^ 4'hA);
        run_start(1'b1, 32'd0, 32'd16, 4'hA, 34, 1'b0, 32'd0, es);
        @(negedge clk);
        check("fill_busy", {31'd0, busy}, 32'd1);
        wait_idle(60);
        for (int k = 0; k < 16; k++) check($sformatf("fill_ram%0d", k), {28'd0, ram[k]},
                                            {28'd0, 4'(k) ^ 4'hA});
        check("fill_ram16", {28'd0, ram[16]}, 32'd7);

        // SIGN over preloaded 1..8; hand-computed signature 0x16
        for (int i = 0; i < 8; i++) preload(12'(100 + i), 4'(i + 1));
        run_start(1'b0, 32'd100, 32'd8, 4'h0, 10, 1'b0, 32'd0, 32'h16);
        wait_idle(40);
        for (int i = 0; i < 8; i++) check($sformatf("sign_ram%0d", 100 + i),
                                           {28'd0, ram[100 + i]}, 32'(i + 1));

        // Bit 0 of the word read from address 5 is corrupted on the way back
        flip_en = 1'b1;
        es = '0;
        for (int k = 0; k < 16; k++) begin
            d = 4'(k) ^ 4'h5;
            if (k == 5) d = d ^ 4'h1;
            es = sig_ref(es, d);
        end
        run_start(1'b1, 32'd0, 32'd16, 4'h5, 34, 1'b0, 32'd1, es);
        wait_idle(60);
        flip_en = 1'b0;
        check("flip_ram5", {28'd0, ram[5]}, 32'd1);
        check("flip_ram6", {28'd0, ram[6]}, 32'd3);

        // Out-of-range: 4090 + 10 > 4096; only PARK may ever be driven
        run_start(1'b1, 32'd4090, 32'd10, 4'h3, 1, 1'b1, 32'd0, 32'd0);
        for (int i = 0; i < 3; i++) begin
            check("cfg_raddr", raddr, PARK);
            check("cfg_waddr", waddr, PARK);
            @(negedge clk);
        end
        wait_idle(10);

        // Zero length
        run_start(1'b1, 32'd5, 32'd0, 4'h3, 1, 1'b0, 32'd0, 32'd0);
        wait_idle(10);

        // Second start mid-FILL must be ignored
        es = '0;
        for (int k = 0; k < 12; k++) es = sig_ref(es, 4'(200 + k) ^ 4'h6);
        run_start(1'b1, 32'd200, 32'd12, 4'h6, 26, 1'b0, 32'd0, es);
        repeat (3) @(negedge clk);
        start = 1'b1; mode = 1'b0; base = 32'd7; len = 32'd1; seed = 4'h0;
        @(posedge clk);
        #1 start = 1'b0;
        wait_idle(60);
        for (int k = 0; k < 12; k++) check($sformatf("ign_ram%0d", 200 + k),
                                            {28'd0, ram[200 + k]}, {28'd0, 4'(200 + k) ^ 4'h6});

        // Reset mid-READ of a SIGN sweep
        run_start(1'b0, 32'd100, 32'd8, 4'h0, 10, 1'b0, 32'd0, 32'h16);
        repeat (4) @(negedge clk);
        check("midread_busy", {31'd0, busy}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        exp_q.delete();
        check("mrst_raddr", raddr, PARK);
        check("mrst_waddr", waddr, PARK);
        check("mrst_din", {28'd0, din}, 32'd0);
        check("mrst_flags", {29'd0, busy, done, cfg_err}, 32'd0);
        check("mrst_sig", signature, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        es = '0;
        for (int k = 0; k < 5; k++) es = sig_ref(es, 4'(300 + k) ^ 4'hC);
        run_start(1'b1, 32'd300, 32'd5, 4'hC, 12, 1'b0, 32'd0, es);
        wait_idle(30);
        for (int k = 0; k < 5; k++) check($sformatf("post_ram%0d", 300 + k),
                                           {28'd0, ram[300 + k]}, {28'd0, 4'(300 + k) ^ 4'hC});
        check("post_ram100", {28'd0, ram[100]}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
